async_fifo_wr_ptr: RTL and testbench
====================================

Name: async_fifo_wr_ptr

Overview:
- Write-side pointer and flag generator for the async FIFO, running in the source (write) clock domain.
- Keeps the binary write counter and produces the RAM write address.
- Produces the registered Gray-coded write pointer that the two-flop pointer synchronizer carries into the read domain.
- Derives the full flag from the read pointer that has been synchronized back into this domain.

Parameters:
- ASIZE, 4, address width; FIFO depth = 2^ASIZE; minimum 2; pointers are ASIZE+1 bits.
- AFULL_THRESH, 2^ASIZE-2, fill level at or above which walmost_full asserts (used only with ALMOST_FULL_EN).

Ports:
- src_clk  in  1  write-domain clock.
- src_rst_n  in  1  asynchronous active-low reset.
- winc  in  1  write request; the FIFO RAM write enable is winc & ~wfull.
- wq2_rptr  in  ASIZE+1  Gray read pointer, already synchronized into src_clk.
- waddr  out  ASIZE  RAM write address, equal to wbin[ASIZE-1:0].
- wptr  out  ASIZE+1  registered Gray write pointer, sent to the synchronizer.
- wfull  out  1  registered full flag.
- wovf  out  1  one-cycle pulse: a write was attempted while full and dropped.
- walmost_full  out  1  registered almost-full flag; tied 0 without ALMOST_FULL_EN.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset bridge):
  - wbin = 0, wptr = 0, wfull = 0, wovf = 0, walmost_full = 0, waddr = 0.
  - Reset asserted mid-operation clears everything immediately, independent of the clock. The read side must be reset together with it.
- Accept: wacc = winc & ~wfull, evaluated against the current registered wfull.
- Next-state arithmetic:
  - wbin_next = wbin + wacc, modulo 2^(ASIZE+1). Wrap from all-ones to 0 is natural with no special case.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Each src_clk edge:
  - wbin <= wbin_next.
  - wptr <= wgray_next.
  - wptr changes by exactly one bit per accepted write and never changes without an accept. This is the required CDC invariant.
- Full:
  - wfull <= (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}).
  - Asserts on the same edge that the filling write is registered, so there is zero-cycle exposure to overflow.
  - Deasserts one src_clk edge after wq2_rptr changes so the equality no longer holds.
  - Full is pessimistic because of synchronizer lag. It never overflows the RAM.
- Overflow: wovf <= winc & wfull. It is a single pulse per attempted write, and consecutive attempts give consecutive pulses. A dropped write leaves wbin, wptr and waddr unchanged.
- Simultaneous winc with wq2_rptr advancing while full: the write is dropped, because accept uses the registered wfull. wfull drops on that edge and the next winc is accepted.
- waddr is a direct slice of the wbin register with no combinational path from winc.

Optional Feature:
- Macro: ASYNC_FIFO_ALMOST_FULL_EN.
- When defined:
  - Convert wq2_rptr Gray to binary: rbin[i] = XOR of wq2_rptr[ASIZE:i].
  - wlevel = wbin_next - rbin, modulo 2^(ASIZE+1).
  - walmost_full <= (wlevel >= AFULL_THRESH).
  - Assertion is pessimistic by the synchronizer lag.
  - walmost_full and wfull both hold when the FIFO is full.
- When undefined: walmost_full is tied to 0, no Gray-to-binary logic is instantiated, and AFULL_THRESH is ignored.

Test Plan:
- Reset then idle: src_rst_n low mid-cycle, wq2_rptr = 0 -> all outputs 0 immediately; after release with winc = 0 for 10 cycles, wptr stays 0 and wfull stays 0.
- Fill, ASIZE = 2, wq2_rptr = 0: 4 consecutive winc -> wptr steps 0, 1, 3, 2, 6; waddr steps 0, 1, 2, 3, 0; wfull = 1 on the 4th edge.
- Overflow: continue from full with winc held high for 2 cycles -> wovf high for 2 cycles, wptr stays 6, waddr stays 0, wfull stays 1.
- Release: set wq2_rptr = 1 (Gray) -> wfull = 0 one edge later; next winc accepted, wptr becomes 7 (Gray of 5).
- Wrap, ASIZE = 2: wq2_rptr tracks wptr after 2 cycles of lag while winc is held for 8 accepts -> wptr sequence 1, 3, 2, 6, 7, 5, 4, 0; one bit changes per step; wfull never asserts.
- With ASYNC_FIFO_ALMOST_FULL_EN, ASIZE = 2, AFULL_THRESH = 3, wq2_rptr = 0: 3 writes -> walmost_full = 1 on the 3rd edge with wfull = 0; 4th write -> both flags 1. Without the macro, walmost_full stays 0 throughout.

Source files
------------

// File: rtl/async_fifo_wr_ptr.sv
// Write-side pointer and flag generator for an async FIFO (src_clk domain).
// Optional almost-full flag is built when ASYNC_FIFO_ALMOST_FULL_EN is defined.
module async_fifo_wr_ptr #(
    parameter int ASIZE        = 4,
    parameter int AFULL_THRESH = (1 << ASIZE) - 2
) (
    input  logic             src_clk,
    input  logic             src_rst_n,
    input  logic             winc,
    input  logic [ASIZE:0]   wq2_rptr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             wovf,
    output logic             walmost_full
);

    logic [ASIZE:0] wbin_q, wbin_d;
    logic [ASIZE:0] wptr_q, wptr_d;
    logic           wfull_q, wfull_d;
    logic           wovf_q, wovf_d;
    logic           walmost_full_q, walmost_full_d;
    logic           wacc;
    logic [ASIZE:0] full_cmp;

    // Accept uses the registered full flag, so a write racing a read-pointer
    // update while full is dropped; the next one goes through.
    assign wacc     = winc & ~wfull_q;
    assign full_cmp = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};

    always_comb begin
        wbin_d  = wbin_q + {{ASIZE{1'b0}}, wacc};
        wptr_d  = (wbin_d >> 1) ^ wbin_d;
        wfull_d = (wptr_d == full_cmp);
        wovf_d  = winc & wfull_q;
    end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    localparam logic [ASIZE:0] AFULL_LVL = AFULL_THRESH[ASIZE:0];

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] wlevel;

    always_comb begin
        rbin[ASIZE] = wq2_rptr[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
        wlevel         = wbin_d - rbin;
        walmost_full_d = (wlevel >= AFULL_LVL);
    end
`else
    assign walmost_full_d = 1'b0;
`endif

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            wovf_q         <= 1'b0;
            walmost_full_q <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            wovf_q         <= wovf_d;
            walmost_full_q <= walmost_full_d;
        end
    end

    assign waddr        = wbin_q[ASIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign wovf         = wovf_q;
    assign walmost_full = walmost_full_q;

endmodule

// File: tb/tb_async_fifo_wr_ptr.sv
// Directed bench for async_fifo_wr_ptr with ASIZE = 2, AFULL_THRESH = 3.
module tb_async_fifo_wr_ptr;

  localparam int ASIZE = 2;

  logic             src_clk;
  logic             src_rst_n;
  logic             winc;
  logic [ASIZE:0]   wq2_rptr;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             wovf;
  logic             walmost_full;

  int checks = 0;
  int errors = 0;

  async_fifo_wr_ptr #(
    .ASIZE        (ASIZE),
    .AFULL_THRESH (3)
  ) dut (
    .src_clk      (src_clk),
    .src_rst_n    (src_rst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .wovf         (wovf),
    .walmost_full (walmost_full)
  );

  // clock / reset
  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic af_exp(input logic v);
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag, input logic [2:0] e_ptr, input logic [1:0] e_addr,
                           input logic e_full, input logic e_ovf, input logic e_af);
    check({tag, ".wptr"},  32'(wptr),         32'(e_ptr));
    check({tag, ".waddr"}, 32'(waddr),        32'(e_addr));
    check({tag, ".wfull"}, 32'(wfull),        32'(e_full));
    check({tag, ".wovf"},  32'(wovf),         32'(e_ovf));
    check({tag, ".waf"},   32'(walmost_full), 32'(af_exp(e_af)));
  endtask

  logic [2:0] g_seq [8];
  logic [2:0] f_ptr [4];
  logic [1:0] f_addr [4];
  logic [2:0] prev_ptr;

  initial begin
    g_seq[0] = 3'd1; g_seq[1] = 3'd3; g_seq[2] = 3'd2; g_seq[3] = 3'd6;
    g_seq[4] = 3'd7; g_seq[5] = 3'd5; g_seq[6] = 3'd4; g_seq[7] = 3'd0;
    f_ptr[0] = 3'd1; f_ptr[1] = 3'd3; f_ptr[2] = 3'd2; f_ptr[3] = 3'd6;
    f_addr[0] = 2'd1; f_addr[1] = 2'd2; f_addr[2] = 2'd3; f_addr[3] = 2'd0;

    // reset asserted mid-cycle, outputs clear without a clock edge
    src_rst_n = 1'b1;
    winc      = 1'b0;
    wq2_rptr  = '0;
    #12;
    src_rst_n = 1'b0;
    #1;
    check_all("reset", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    src_rst_n = 1'b1;

    // idle
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle.wptr", 32'(wptr), 32'd0);
      check("idle.wfull", 32'(wfull), 32'd0);
    end

    // fill
    winc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("fill%0d", i), f_ptr[i], f_addr[i], (i == 3), 1'b0, (i >= 2));
    end

    // overflow: two dropped writes
    tick();
    check_all("ovf0", 3'd6, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    check_all("ovf1", 3'd6, 2'd0, 1'b1, 1'b1, 1'b1);
    winc = 1'b0;
    tick();
    check_all("ovf_end", 3'd6, 2'd0, 1'b1, 1'b0, 1'b1);

    // release: read pointer advances to 1
    wq2_rptr = 3'd1;
    tick();
    check_all("release", 3'd6, 2'd0, 1'b0, 1'b0, 1'b1);
    winc = 1'b1;
    tick();
    check_all("refill", 3'd7, 2'd1, 1'b1, 1'b0, 1'b1);

    // write racing a read-pointer advance while full is dropped
    wq2_rptr = 3'd3;
    tick();
    check_all("race_drop", 3'd7, 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    check_all("race_next", 3'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    winc = 1'b0;

    // reset mid-operation
    #3;
    src_rst_n = 1'b0;
    #1;
    check_all("midreset", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    wq2_rptr = '0;
    tick();
    src_rst_n = 1'b1;
    tick();
    check_all("post_reset", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // wrap with read pointer trailing by two edges
    prev_ptr = wptr;
    winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wq2_rptr = (i >= 3) ? g_seq[i-3] : 3'd0;
      tick();
      check_all($sformatf("wrap%0d", i), g_seq[i], 2'(i + 1), 1'b0, 1'b0, (i >= 2));
      check($sformatf("wrap%0d.onebit", i), 32'($countones(wptr ^ prev_ptr)), 32'd1);
      prev_ptr = wptr;
    end
    winc = 1'b0;
    tick();
    check("wrap_hold.wptr", 32'(wptr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
